seg7_disp_arbiter: RTL and testbench

// - Shares the single 8-digit seven-segment display driver between N requesters (PC, register, memory-data, etc. debug views).
// - Round-robin scheduler: each requester holds the display for a dwell time, then yields if others are waiting.
// - Manual override selects one source from the board switches.
// - Outputs drive the display driver's 32-bit data input and disp_mode input directly.

---
 rtl/seg7_disp_arbiter.sv | 113 +++++++++++
 tb/tb_seg7_disp_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter: round-robin/manual arbiter sharing one 8-digit seven-segment driver among N sources.
// Define SEG7_ARB_TAG_EN to show the grantee index on the top hex digit.
module seg7_disp_arbiter #(
  parameter int N = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req,
  input  logic [32*N-1:0]   req_data,
  input  logic [N-1:0]      req_mode,
  input  logic              manual_en,
  input  logic [IDX_W-1:0]  manual_idx,
  input  logic              freeze,
  output logic [N-1:0]      gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [31:0]       o_data,
  output logic              o_disp_mode,
  output logic              busy
);
  localparam int CW = $clog2(DWELL_CYCLES);
  typedef enum logic [1:0] {IDLE, ARB, SHOW} state_t;
  state_t state, state_n;
  logic [N-1:0] gnt_n;
  logic [IDX_W-1:0] idx_n, ptr, ptr_n, pick, midx;
  logic [CW-1:0] cnt, cnt_n;
  logic man, man_n, mode_n, sel_mode;
  logic [31:0] data_n, sel_data, shown;
  assign busy = state == SHOW;
  assign midx = (int'(manual_idx) >= N) ? IDX_W'(N - 1) : manual_idx;
  assign sel_data = req_data[32*int'(gnt_idx) +: 32];
  assign sel_mode = req_mode[gnt_idx];
`ifdef SEG7_ARB_TAG_EN
  assign shown = sel_mode ? sel_data : {4'(gnt_idx), sel_data[27:0]};
`else
  assign shown = sel_data;
`endif
  // Scan offsets high to low so the nearest requester after ptr wins.
  always_comb begin
    pick = '0;
    for (int i = N; i >= 1; i--)
      if (req[IDX_W'((int'(ptr) + i) % N)]) pick = IDX_W'((int'(ptr) + i) % N);
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    idx_n = gnt_idx;
    ptr_n = ptr;
    cnt_n = cnt;
    man_n = man;
    data_n = (state == SHOW && !freeze) ? shown : o_data;
    mode_n = (state == SHOW && !freeze) ? sel_mode : o_disp_mode;
    if (manual_en) begin
      state_n = SHOW;
      gnt_n = N'(1) << midx;
      idx_n = midx;
      cnt_n = '0;
      man_n = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = |req ? ARB : IDLE;
        ARB: begin
          state_n = |req ? SHOW : IDLE;
          if (|req) begin
            gnt_n = N'(1) << pick;
            idx_n = pick;
            ptr_n = pick;
            cnt_n = '0;
          end
        end
        SHOW: begin
          if (man) begin
            state_n = ARB;
            gnt_n = '0;
            man_n = 1'b0;
          end else if (!req[gnt_idx]) begin
            state_n = |req ? ARB : IDLE;
            gnt_n = '0;
          end else if (cnt == CW'(DWELL_CYCLES - 1)) begin
            cnt_n = '0;
            if (|(req & ~gnt)) begin
              state_n = ARB;
              gnt_n = '0;
            end
          end else cnt_n = cnt + 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      ptr <= IDX_W'(N - 1);
      cnt <= '0;
      man <= 1'b0;
      o_data <= '0;
      o_disp_mode <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      man <= man_n;
      o_data <= data_n;
      o_disp_mode <= mode_n;
    end
  end
endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// tb_seg7_disp_arbiter: directed vector table plus hand sequences for rotation, drop, freeze, manual and reset.
module tb_seg7_disp_arbiter;
  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] req = '0, req_mode = '0, gnt;
  logic [31:0] dat [4];
  logic [127:0] req_data;
  logic manual_en = 1'b0, freeze = 1'b0, o_disp_mode, busy;
  logic [1:0] manual_idx = '0, gnt_idx;
  logic [31:0] o_data;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] req;
    logic men;
    logic [1:0] midx;
    logic [3:0] gnt;
    logic busy;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [20];
  assign req_data = {dat[3], dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;
  seg7_disp_arbiter #(.N(4), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .req_mode(req_mode),
    .manual_en(manual_en), .manual_idx(manual_idx), .freeze(freeze),
    .gnt(gnt), .gnt_idx(gnt_idx), .o_data(o_data), .o_disp_mode(o_disp_mode), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    req = '0;
    manual_en = 1'b0;
    manual_idx = '0;
    freeze = 1'b0;
    req_mode = '0;
    rstn = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
  endtask
  initial begin
    int ord [4] = '{0, 1, 3, 0};
    bit nz;
    dat[0] = 32'h1234_5678;
    dat[1] = 32'h1111_1111;
    dat[2] = 32'h2222_2222;
    dat[3] = 32'h3333_3333;
    tbl[0] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 32'h0};
    tbl[1] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 32'h0};
    for (int i = 2; i <= 12; i++) tbl[i] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 32'h1234_5678};
    tbl[13] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 32'h1234_5678};
    tbl[14] = '{4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 32'h1234_5678};
    tbl[15] = '{4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 32'h2222_2222};
    tbl[16] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 32'h2222_2222};
    tbl[17] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 32'h3333_3333};
    tbl[18] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 32'h3333_3333};
    tbl[19] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 32'h3333_3333};
    do_reset;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", 32'(busy), 0);
    foreach (tbl[i]) begin
      req = tbl[i].req;
      manual_en = tbl[i].men;
      manual_idx = tbl[i].midx;
      tick;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_data", i), o_data, tbl[i].data);
    end
    // round robin 0,1,3,0 with 8-cycle slots
    do_reset;
    req = 4'b1011;
    tick;
    chk("rr_arb0", 32'(gnt), 0);
    nz = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        tick;
        chk($sformatf("rr%0d_%0d_gnt", s, c), 32'(gnt), 32'(1) << ord[s]);
        if (c == 0) chk($sformatf("rr%0d_idx", s), 32'(gnt_idx), ord[s]);
        if (c == 1) chk($sformatf("rr%0d_data", s), o_data, dat[ord[s]]);
        if ((s > 0 || c > 0) && o_data == 0) nz = 1'b0;
      end
      tick;
      chk($sformatf("rr%0d_arb", s), 32'(gnt), 0);
      if (o_data == 0) nz = 1'b0;
    end
    chk("rr_nonzero", 32'(nz), 1);
    // manual holds through 30 cycles of competing requests
    manual_en = 1'b1;
    manual_idx = 2'd2;
    for (int c = 0; c < 30; c++) begin
      tick;
      chk($sformatf("man_%0d", c), 32'(gnt), 32'b0100);
    end
    manual_en = 1'b0;
    tick;
    chk("man_off_gnt", 32'(gnt), 0);
    chk("man_off_busy", 32'(busy), 0);
    tick;
    chk("man_off_pick", 32'(gnt), 32'b0010);
    // grantee drop at count 3 with another pending
    do_reset;
    req = 4'b0010;
    repeat (5) tick;
    chk("drop_pre", 32'(gnt), 32'b0010);
    req = 4'b0100;
    tick;
    chk("drop_arb", 32'(gnt), 0);
    tick;
    chk("drop_new", 32'(gnt), 32'b0100);
    // grantee drop with nobody waiting
    do_reset;
    req = 4'b0010;
    repeat (5) tick;
    req = 4'b0000;
    tick;
    chk("drop_idle_busy", 32'(busy), 0);
    chk("drop_idle_gnt", 32'(gnt), 0);
    tick;
    chk("drop_idle_data", o_data, 32'h1111_1111);
    chk("drop_idle_stay", 32'(busy), 0);
    // freeze holds display while FSM continues
    do_reset;
    dat[0] = 32'hAAAA_AAAA;
    req = 4'b0001;
    repeat (3) tick;
    chk("frz_pre", o_data, 32'hAAAA_AAAA);
    freeze = 1'b1;
    dat[0] = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("frz_%0d_data", c), o_data, 32'hAAAA_AAAA);
      chk($sformatf("frz_%0d_gnt", c), 32'(gnt), 32'b0001);
    end
    freeze = 1'b0;
    tick;
    chk("frz_off", o_data, 32'h5555_5555);
    // source 3 hex mode, then raw mode
    dat[3] = 32'hFFFF_FFFF;
    manual_en = 1'b1;
    manual_idx = 2'd3;
    tick;
    tick;
`ifdef SEG7_ARB_TAG_EN
    chk("tag_hex", o_data, 32'h3FFF_FFFF);
`else
    chk("tag_hex", o_data, 32'hFFFF_FFFF);
`endif
    req_mode = 4'b1000;
    tick;
    chk("raw_data", o_data, 32'hFFFF_FFFF);
    chk("raw_mode", 32'(o_disp_mode), 1);
    // asynchronous reset mid-SHOW
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_data", o_data, 0);
    chk("arst_mode", 32'(o_disp_mode), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(gnt_idx), 0);
    manual_en = 1'b0;
    tick;
    rstn = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
